// File: rtl/cotm32_pipeline_pkg.sv
// Shared pipeline types and helpers for the cotm32 front end.
// Holds the IF/ID payload layout, the NOP encoding and the pointer wrap helper.
package cotm32_pipeline_pkg;

  localparam logic [31:0] INST_NOP  = 32'h0000_0013;
  localparam int          PTR_MAX_W = 3;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ifid_data_t;

  typedef struct packed {
    logic access_fault;
    logic misaligned;
  } ifid_trap_t;

  // Ring pointer advance: wraps from depth-1 back to 0 (depth need not be a power of 2).
  function automatic logic [PTR_MAX_W-1:0] ptr_inc_wrap(
    input logic [PTR_MAX_W-1:0] ptr,
    input logic [PTR_MAX_W:0]   depth
  );
    logic [PTR_MAX_W-1:0] nxt;
    if ({1'b0, ptr} == (depth - (PTR_MAX_W+1)'(1))) begin
      nxt = {PTR_MAX_W{1'b0}};
    end else begin
      nxt = ptr + PTR_MAX_W'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pipe_elastic_reg.sv
// Elastic pipeline register: small in-order FIFO between pipeline stages.
// o_ready depends only on registered occupancy, so no ready path crosses the stage.
module pipe_elastic_reg
  import cotm32_pipeline_pkg::*;
#(
  parameter int                 DATA_W     = 64,
  parameter int                 TRAP_W     = 2,
  parameter int                 DEPTH      = 2,
  parameter logic [DATA_W-1:0]  FLUSH_DATA = DATA_W'(INST_NOP)
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_flush,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [DATA_W-1:0]           i_data,
  input  logic [TRAP_W-1:0]           i_trap,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [DATA_W-1:0]           o_data,
  output logic [TRAP_W-1:0]           o_trap,
  output logic [$clog2(DEPTH+1)-1:0]  o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = DATA_W + TRAP_W;

  logic [ENT_W-1:0] mem_q [2**PTR_W];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             push_s, pop_s, ready_s, valid_s;
  logic [ENT_W-1:0] head_s;

  assign ready_s = (count_q < CNT_W'(DEPTH));
  assign valid_s = (count_q != CNT_W'(0));
  assign push_s  = i_valid && ready_s;
  assign pop_s   = valid_s && i_ready;
  assign head_s  = mem_q[rd_ptr_q];

  // Next-state for pointers and occupancy; flush overrides any push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      wr_ptr_d = PTR_W'(0);
      rd_ptr_d = PTR_W'(0);
      count_d  = CNT_W'(0);
    end else begin
      if (push_s) begin
        wr_ptr_d = PTR_W'(ptr_inc_wrap(PTR_MAX_W'(wr_ptr_q), (PTR_MAX_W+1)'(DEPTH)));
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = PTR_W'(ptr_inc_wrap(PTR_MAX_W'(rd_ptr_q), (PTR_MAX_W+1)'(DEPTH)));
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= PTR_W'(0);
      rd_ptr_q <= PTR_W'(0);
      count_q  <= CNT_W'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; left unreset because empty slots are never shown on the outputs.
  always_ff @(posedge i_clk) begin
    if (push_s && !i_flush) begin
      mem_q[wr_ptr_q] <= {i_trap, i_data};
    end
  end

  // Output view of the head entry, with the NOP bubble shown while empty.
  always_comb begin
    o_data = FLUSH_DATA;
    o_trap = TRAP_W'(0);
    if (valid_s) begin
      o_data = head_s[DATA_W-1:0];
      o_trap = head_s[ENT_W-1:DATA_W];
    end else begin
      o_data = FLUSH_DATA;
      o_trap = TRAP_W'(0);
    end
  end

  assign o_ready = ready_s;
  assign o_valid = valid_s;
  assign o_count = count_q;

endmodule
